hazard_fwd_unit: RTL

//  Parametrised hazard/forwarding unit for the 5-stage core; generalises the EX->EX-only forwarding check.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/fwd_src_match.sv | 33 +++
 rtl/hazard_fwd_unit.sv | 86 ++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the hazard/forwarding unit.
// Optional perf counters in hazard_fwd_unit are enabled with HAZARD_PERF_CNT_EN.
package hazard_pkg;

    // Entry rd is stored at a fixed width so the struct is parameter-independent.
    localparam int HZ_RD_W = 8;

    localparam int FWD_NONE  = 0;
    localparam int FWD_EXMEM = 1;
    localparam int FWD_MEMWB = 2;

    typedef struct packed {
        logic               valid;
        logic               wr_en;
        logic               is_load;
        logic [HZ_RD_W-1:0] rd;
    } hz_entry_t;

    localparam hz_entry_t HZ_BUBBLE = '{valid: 1'b0, wr_en: 1'b0, is_load: 1'b0, rd: '0};

endpackage

// File: rtl/fwd_src_match.sv
// Per-source priority match of one ID operand against the shadow pipeline.
// Youngest matching producer wins; load_hit flags a load sitting in S0.
module fwd_src_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int FWD_DEPTH  = 2,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic [REG_ADDR_W-1:0]       src,
    input  logic                        used,
    input  hz_entry_t [FWD_DEPTH-1:0]   stages,
    output logic [SEL_W-1:0]            sel,
    output logic                        load_hit
);

    logic hit_is_load;

    always_comb begin
        sel         = SEL_W'(FWD_NONE);
        hit_is_load = 1'b0;
        // Walk oldest to youngest so the youngest match overwrites.
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (used && (src != '0) && stages[k].valid && stages[k].wr_en &&
                (stages[k].rd == HZ_RD_W'(src))) begin
                sel         = SEL_W'(k + 1);
                hit_is_load = stages[k].is_load;
            end
        end
        load_hit = hit_is_load && (sel == SEL_W'(FWD_EXMEM));
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding unit: shadow pipeline of in-flight destinations, registered
// operand selects for ID/EX and a combinational load-use stall. Perf counters: HAZARD_PERF_CNT_EN.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          advance,
    input  logic                          flush,
    input  logic                          id_valid,
    input  logic                          id_wr_en,
    input  logic                          id_is_load,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_used,
    output logic                          stall,
    output logic [NUM_SRC*SEL_W-1:0]      ex_fwd_sel,
    output logic                          ex_fwd_any
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                   stall_cnt,
    output logic [31:0]                   fwd_cnt
`endif
);

    hz_entry_t [FWD_DEPTH-1:0]       shadow;
    hz_entry_t                       id_entry;
    logic [NUM_SRC-1:0][SEL_W-1:0]   sel_d;
    logic [NUM_SRC-1:0][SEL_W-1:0]   sel_q;
    logic [NUM_SRC-1:0]              load_hit;
    logic                            accept;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .FWD_DEPTH  (FWD_DEPTH),
            .SEL_W      (SEL_W)
        ) u_match (
            .src      (id_src[i*REG_ADDR_W +: REG_ADDR_W]),
            .used     (id_src_used[i]),
            .stages   (shadow),
            .sel      (sel_d[i]),
            .load_hit (load_hit[i])
        );
    end

    // Flush dominates stall: a squashed instruction never needs to wait.
    assign stall  = id_valid & ~flush & (|load_hit);
    assign accept = id_valid & ~stall & ~flush;

    always_comb begin
        id_entry = '{valid: 1'b1, wr_en: id_wr_en, is_load: id_is_load, rd: HZ_RD_W'(id_rd)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < FWD_DEPTH; k++) shadow[k] <= HZ_BUBBLE;
            sel_q <= '0;
        end else if (advance) begin
            for (int k = FWD_DEPTH - 1; k > 0; k--) shadow[k] <= shadow[k-1];
            shadow[0] <= accept ? id_entry : HZ_BUBBLE;
            sel_q     <= accept ? sel_d : '0;
        end
    end

    assign ex_fwd_sel = sel_q;
    assign ex_fwd_any = |sel_q;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && advance && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (advance && accept && (|sel_d) && (fwd_cnt != '1)) fwd_cnt <= fwd_cnt + 32'd1;
        end
    end
`endif

endmodule
